// File: rtl/io_port_bank_pkg.sv
// Register map and bit positions for the I/O port bank; shared by RTL and the MMU-side bench.
package io_port_bank_pkg;

  typedef enum logic [5:0] {
    REG_GPIO_OUT = 6'h00,
    REG_GPIO_IN  = 6'h01,
    REG_CON_DATA = 6'h02,
    REG_CON_STAT = 6'h03,
    REG_TMR_CNT  = 6'h04,
    REG_TMR_CMP  = 6'h05,
    REG_TMR_CTRL = 6'h06
  } io_reg_e;

  localparam int STAT_FULL   = 0;
  localparam int STAT_EMPTY  = 1;
  localparam int STAT_OVF    = 2;
  localparam int STAT_CNT    = 3;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_IRQ_EN = 1;
  localparam int CTRL_PEND   = 2;

  function automatic logic [7:0] reg_addr(io_reg_e r);
    return {r, 2'b00};
  endfunction

endpackage

// File: rtl/io_fifo.sv
// Small circular byte FIFO; a push into a full FIFO is accepted only when a pop frees a slot.
module io_fifo #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 4,
  parameter int DEPTH_LOG = 2
) (
  input  logic                 clk,
  input  logic                 resetb,
  input  logic                 i_push,
  input  logic [WIDTH-1:0]     i_din,
  input  logic                 i_pop,
  output logic                 o_full,
  output logic                 o_empty,
  output logic [DEPTH_LOG:0]   o_count,
  output logic [WIDTH-1:0]     o_head
);

  logic [DEPTH-1:0][WIDTH-1:0] r_mem;
  logic [DEPTH_LOG-1:0]        r_wr;
  logic [DEPTH_LOG-1:0]        r_rd;
  logic [DEPTH_LOG:0]          r_cnt;
  logic                        w_push;
  logic                        w_pop;

  assign o_full  = (r_cnt == (DEPTH_LOG+1)'(DEPTH));
  assign o_empty = (r_cnt == '0);
  assign o_count = r_cnt;
  assign o_head  = r_mem[r_rd];
  assign w_pop   = i_pop && !o_empty;
  assign w_push  = i_push && (!o_full || w_pop);

  // storage is cleared too so the head byte reads 0 out of reset
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      r_mem <= '0;
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= i_din;
        r_wr        <= r_wr + 1'b1;
      end
      if (w_pop) r_rd <= r_rd + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/io_port_bank.sv
// MMU I/O window responder: GPIO, compare-match timer with IRQ, console FIFO.
// Reads are registered; the MMU picks up io_data_read one cycle after the access.
module io_port_bank
  import io_port_bank_pkg::*;
#(
  parameter int GPIO_W     = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int FIFO_LOG   = 2
) (
  input  logic              clk,
  input  logic              resetb,
  input  logic [7:0]        io_addr,
  input  logic              io_en,
  input  logic              io_we,
  input  logic [31:0]       io_data_write,
  output logic [31:0]       io_data_read,
  output logic [GPIO_W-1:0] gpio_out,
  input  logic [GPIO_W-1:0] gpio_in,
  output logic [7:0]        con_data,
  output logic              con_valid,
  input  logic              con_ready,
  output logic              timer_irq
);

  io_reg_e             w_reg;
  logic                w_rd, w_wr, w_match, w_pop, w_push;
  logic                w_full, w_empty, w_unused;
  logic [FIFO_LOG:0]   w_count;
  logic [31:0]         w_rdata;
  logic [31:0]         r_rdata, r_cnt, r_cmp;
  logic [GPIO_W-1:0]   r_gpio, r_sync1, r_sync2;
  logic                r_en, r_irq_en, r_pend, r_ovf;

  assign w_reg    = io_reg_e'(io_addr[7:2]);
  assign w_unused = ^io_addr[1:0];
  assign w_rd     = io_en && !io_we;
  assign w_wr     = io_en && io_we;
  assign w_push   = w_wr && (w_reg == REG_CON_DATA);
  assign w_pop    = con_ready && !w_empty;
  assign w_match  = r_en && (r_cnt == r_cmp);

  io_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH), .DEPTH_LOG(FIFO_LOG)) u_fifo (
    .clk     (clk),
    .resetb  (resetb),
    .i_push  (w_push),
    .i_din   (io_data_write[7:0]),
    .i_pop   (con_ready),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count),
    .o_head  (con_data)
  );

  always_comb begin
    w_rdata = '0;
    case (w_reg)
      REG_GPIO_OUT: w_rdata[GPIO_W-1:0] = r_gpio;
      REG_GPIO_IN:  w_rdata[GPIO_W-1:0] = r_sync2;
      REG_CON_STAT: begin
        w_rdata[STAT_FULL]               = w_full;
        w_rdata[STAT_EMPTY]              = w_empty;
        w_rdata[STAT_OVF]                = r_ovf;
        w_rdata[STAT_CNT +: FIFO_LOG+1]  = w_count;
      end
      REG_TMR_CNT:  w_rdata = r_cnt;
      REG_TMR_CMP:  w_rdata = r_cmp;
      REG_TMR_CTRL: begin
        w_rdata[CTRL_EN]     = r_en;
        w_rdata[CTRL_IRQ_EN] = r_irq_en;
        w_rdata[CTRL_PEND]   = r_pend;
      end
      default:      w_rdata = '0;
    endcase
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      r_rdata  <= '0;
      r_gpio   <= '0;
      r_sync1  <= '0;
      r_sync2  <= '0;
      r_cnt    <= '0;
      r_cmp    <= '0;
      r_en     <= 1'b0;
      r_irq_en <= 1'b0;
      r_pend   <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      r_sync1 <= gpio_in;
      r_sync2 <= r_sync1;
      if (w_rd) r_rdata <= w_rdata;
      if (w_wr && w_reg == REG_GPIO_OUT) r_gpio <= io_data_write[GPIO_W-1:0];
      if (w_wr && w_reg == REG_TMR_CMP)  r_cmp  <= io_data_write;
      if (w_wr && w_reg == REG_TMR_CTRL) begin
        r_en     <= io_data_write[CTRL_EN];
        r_irq_en <= io_data_write[CTRL_IRQ_EN];
      end
      // a software count write beats both the match wrap and the increment
      if (w_wr && w_reg == REG_TMR_CNT) r_cnt <= io_data_write;
      else if (w_match)                 r_cnt <= '0;
      else if (r_en)                    r_cnt <= r_cnt + 32'd1;
      if (w_match)                                                   r_pend <= 1'b1;
      else if (w_wr && w_reg == REG_TMR_CTRL && io_data_write[CTRL_PEND]) r_pend <= 1'b0;
      if (w_wr && w_reg == REG_CON_STAT)       r_ovf <= 1'b0;
      else if (w_push && w_full && !w_pop)     r_ovf <= 1'b1;
    end
  end

  assign io_data_read = r_rdata;
  assign gpio_out     = r_gpio;
  assign con_valid    = !w_empty;
  assign timer_irq    = r_pend && r_irq_en;

endmodule

// File: tb/tb_io_port_bank.sv
// Scoreboard bench for io_port_bank: a queue-based model predicts reads and console bytes.
module tb_io_port_bank;
  import io_port_bank_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        resetb = 1'b0;
  logic [7:0]  io_addr = '0;
  logic        io_en = 1'b0, io_we = 1'b0;
  logic [31:0] io_data_write = '0;
  logic [31:0] io_data_read;
  logic [31:0] gpio_out, gpio_in = '0;
  logic [7:0]  con_data;
  logic        con_valid, timer_irq;
  logic        con_ready = 1'b0;

  always #5 clk = ~clk;

  io_port_bank #(.GPIO_W(32), .FIFO_DEPTH(DEPTH), .FIFO_LOG(2)) dut (
    .clk(clk), .resetb(resetb), .io_addr(io_addr), .io_en(io_en), .io_we(io_we),
    .io_data_write(io_data_write), .io_data_read(io_data_read), .gpio_out(gpio_out),
    .gpio_in(gpio_in), .con_data(con_data), .con_valid(con_valid), .con_ready(con_ready),
    .timer_irq(timer_irq)
  );

  int vectors = 0, miscompares = 0;
  logic [31:0] rdq[$];
  logic [7:0]  conq[$];
  bit exp_irq = 0, exp_cvalid = 0, rd_due = 0;

  // behavioural model state
  logic [31:0] m_gpio, m_cnt, m_cmp;
  bit          m_en, m_irqen, m_pend, m_ovf;
  logic [7:0]  m_fifo[$];
  logic [31:0] m_gin[2];

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void missing(string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: DUT output with no expected entry at %0t", name, $time);
  endfunction

  task automatic model_reset();
    m_gpio = 0; m_cnt = 0; m_cmp = 0;
    m_en = 0; m_irqen = 0; m_pend = 0; m_ovf = 0;
    m_fifo.delete(); m_gin[0] = 0; m_gin[1] = 0;
    rdq.delete(); conq.delete();
    exp_irq = 0; exp_cvalid = 0; rd_due = 0;
  endtask

  // Drive one access at posedge+1, predict its effects, then advance to the next posedge+1.
  task automatic step(bit en, bit we, logic [7:0] addr, logic [31:0] wd);
    logic [31:0] rv;
    bit wr, pop, match;
    io_reg_e r;
    io_en = en; io_we = we; io_addr = addr; io_data_write = wd;
    r  = io_reg_e'(addr[7:2]);
    wr = en && we;
    exp_irq    = m_pend && m_irqen;
    exp_cvalid = m_fifo.size() != 0;
    if (en && !we) begin
      case (r)
        REG_GPIO_OUT: rv = m_gpio;
        REG_GPIO_IN:  rv = m_gin[1];
        REG_CON_STAT: rv = 32'(m_fifo.size() == DEPTH) | (32'(m_fifo.size() == 0) << 1)
                           | (32'(m_ovf) << 2) | (32'(m_fifo.size()) << 3);
        REG_TMR_CNT:  rv = m_cnt;
        REG_TMR_CMP:  rv = m_cmp;
        REG_TMR_CTRL: rv = {29'd0, m_pend, m_irqen, m_en};
        default:      rv = 0;
      endcase
      rdq.push_back(rv);
    end
    pop = (m_fifo.size() != 0) && con_ready;
    if (pop) conq.push_back(m_fifo[0]);
    match = m_en && (m_cnt == m_cmp);
    if (wr && r == REG_TMR_CNT) m_cnt = wd;
    else if (match)             m_cnt = 0;
    else if (m_en)              m_cnt = m_cnt + 1;
    if (match)                                 m_pend = 1;
    else if (wr && r == REG_TMR_CTRL && wd[2]) m_pend = 0;
    if (wr && r == REG_TMR_CTRL) begin m_en = wd[0]; m_irqen = wd[1]; end
    if (wr && r == REG_TMR_CMP)  m_cmp = wd;
    if (wr && r == REG_GPIO_OUT) m_gpio = wd;
    if (wr && r == REG_CON_STAT) m_ovf = 0;
    if (pop) void'(m_fifo.pop_front());
    if (wr && r == REG_CON_DATA) begin
      if (m_fifo.size() < DEPTH) m_fifo.push_back(wd[7:0]);
      else m_ovf = 1;
    end
    m_gin[1] = m_gin[0];
    m_gin[0] = gpio_in;
    @(posedge clk); #1;
  endtask

  task automatic wr(io_reg_e r, logic [31:0] d); step(1, 1, reg_addr(r), d); endtask
  task automatic rd(io_reg_e r);                  step(1, 0, reg_addr(r), 0); endtask
  task automatic idle(int n); for (int i = 0; i < n; i++) step(0, 0, 0, 0); endtask

  task automatic do_reset();
    resetb = 1'b0;
    io_en = 0; io_we = 0;
    #1;
    check("rst_rdata", io_data_read, 0);
    check("rst_gpio_out", gpio_out, 0);
    check("rst_con_valid", con_valid, 0);
    check("rst_con_data", con_data, 0);
    check("rst_irq", timer_irq, 0);
    model_reset();
    @(posedge clk); #1;
    @(posedge clk); #1;
    resetb = 1'b1;
  endtask

  // monitor: read data one edge after the read, console bytes on each handshake
  always @(negedge clk) begin
    if (resetb) begin
      if (rd_due) begin
        if (rdq.size() == 0) missing("rdata");
        else check("rdata", io_data_read, rdq.pop_front());
      end
      rd_due = io_en && !io_we;
      check("con_valid", con_valid, exp_cvalid);
      check("timer_irq", timer_irq, exp_irq);
      if (con_valid && con_ready) begin
        if (conq.size() == 0) missing("con_data");
        else check("con_data", con_data, conq.pop_front());
      end
    end
  end

  initial begin
    model_reset();
    @(posedge clk); #1;
    do_reset();
    rd(REG_CON_STAT);
    // GPIO loopback and input synchroniser latency
    wr(REG_GPIO_OUT, 32'hA5A5_0F0F);
    rd(REG_GPIO_OUT);
    gpio_in = 32'h3;
    for (int i = 0; i < 4; i++) rd(REG_GPIO_IN);
    // overflow of a stalled console, then drain
    con_ready = 0;
    for (int i = 1; i <= 5; i++) wr(REG_CON_DATA, 32'(8'h11 * i));
    rd(REG_CON_STAT);
    con_ready = 1;
    idle(6);
    rd(REG_CON_STAT);
    // push into a full FIFO while popping
    con_ready = 0;
    for (int i = 1; i <= 4; i++) wr(REG_CON_DATA, 32'(8'h10 + i));
    con_ready = 1;
    wr(REG_CON_DATA, 32'h66);
    con_ready = 0;
    rd(REG_CON_STAT);
    con_ready = 1;
    idle(6);
    wr(REG_CON_STAT, 0);
    // compare-match timer, W1C and W1C racing a match
    wr(REG_TMR_CTRL, 0); wr(REG_TMR_CNT, 0); wr(REG_TMR_CMP, 3); wr(REG_TMR_CTRL, 3);
    for (int i = 0; i < 6; i++) rd(REG_TMR_CNT);
    wr(REG_TMR_CTRL, 7);
    for (int i = 0; i < 6; i++) wr(REG_TMR_CTRL, 7);
    rd(REG_TMR_CTRL);
    // unmapped/write-only reads and counter wrap without a match
    step(1, 0, 8'hFC, 0);
    wr(REG_TMR_CTRL, 4); wr(REG_TMR_CMP, 5); wr(REG_TMR_CNT, 32'hFFFF_FFFF); wr(REG_TMR_CTRL, 3);
    rd(REG_TMR_CNT); rd(REG_TMR_CTRL); rd(REG_CON_DATA);
    idle(6); rd(REG_TMR_CTRL);
    // randomized traffic with a reset in the middle
    for (int n = 0; n < 600; n++) begin
      logic [7:0]  a;
      logic [31:0] d;
      int sel;
      if (n == 300) begin do_reset(); rd(REG_CON_STAT); end
      if ($urandom_range(0, 9) == 0) gpio_in = $urandom;
      con_ready = ($urandom_range(0, 2) != 0);
      sel = $urandom_range(0, 8);
      a = (sel < 7) ? reg_addr(io_reg_e'(sel)) : 8'($urandom);
      d = $urandom;
      if (sel == 4 || sel == 5) d = $urandom_range(0, 12);
      if (sel == 6) d = $urandom_range(0, 7);
      step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, a, d);
    end
    idle(3);
    if (rdq.size() != 0 || conq.size() != 0) missing("leftover_expectations");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
